// File: rtl/ram_bank_access_ctrl_pkg.sv
// Shared types and constants for the four-bank RAM request controller.
// The request struct carries a 7-bit flat word address: [6:5] bank, [4:0] word.
package ram_bank_access_ctrl_pkg;

    localparam int BANK_BITS = 2;
    localparam int WORD_BITS = 5;
    localparam int ADDR_BITS = BANK_BITS + WORD_BITS;
    localparam int DATA_BITS = 32;

    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        ACCESS,
        RD_WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] wdata;
    } req_t;

    function automatic logic [BANK_BITS-1:0] addr_bank(input logic [ADDR_BITS-1:0] addr);
        return addr[ADDR_BITS-1:WORD_BITS];
    endfunction

    function automatic logic [WORD_BITS-1:0] addr_word(input logic [ADDR_BITS-1:0] addr);
        return addr[WORD_BITS-1:0];
    endfunction

endpackage

// File: rtl/ram_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module ram_req_fifo
    import ram_bank_access_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    req_t        mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[PW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/ram_bank_access_ctrl.sv
// Request sequencer for the four-bank 32x32 RAM array. Tracks the bank latched in the
// array's registered decoder so that same-bank accesses skip the SELECT cycle.
module ram_bank_access_ctrl
    import ram_bank_access_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RD_LAT  = 1,
    parameter int DW      = 32,
    parameter int AW_WORD = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [6:0]         req_addr,
    input  logic [DW-1:0]      req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_rdata,
    output logic [1:0]         mem_cs_sel,
    output logic [AW_WORD-1:0] mem_addr,
    output logic               mem_rw,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               busy
);

    localparam logic [1:0] RD_CNT_INIT = 2'(RD_LAT - 1);

    state_t state, state_nx;

    req_t push_req;
    req_t head;
    logic fifo_full, fifo_empty;
    logic push, pop;

    logic                 cur_we;
    logic [BANK_BITS-1:0] cur_bank;
    logic [WORD_BITS-1:0] cur_word;
    logic [DW-1:0]        cur_wdata;
    logic [BANK_BITS-1:0] sel_bank;
    logic                 sel_valid;
    logic [1:0]           rd_cnt;
    logic [AW_WORD-1:0]   mem_addr_q;
    logic [DW-1:0]        mem_wdata_q;
    logic                 rsp_valid_q;
    logic [DW-1:0]        rsp_rdata_q;

    assign push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};
    assign push     = req_valid && !fifo_full;

    ram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (sel_valid && (sel_bank == addr_bank(head.addr)))
                        state_nx = ACCESS;
                    else
                        state_nx = SELECT;
                end
            end
            SELECT:  state_nx = ACCESS;
            ACCESS:  state_nx = (cur_we == RW_WRITE) ? IDLE : RD_WAIT;
            RD_WAIT: if (rd_cnt == 2'd0) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cur_we      <= 1'b0;
            cur_bank    <= '0;
            cur_word    <= '0;
            cur_wdata   <= '0;
            sel_bank    <= '0;
            sel_valid   <= 1'b0;
            rd_cnt      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (pop) begin
                cur_we    <= head.we;
                cur_bank  <= addr_bank(head.addr);
                cur_word  <= addr_word(head.addr);
                cur_wdata <= head.wdata;
            end
            if (state == SELECT) begin
                sel_bank  <= cur_bank;
                sel_valid <= 1'b1;
            end
            // Address/data registers load on entry to ACCESS and hold through RD_WAIT/RESP.
            if (state_nx == ACCESS) begin
                mem_addr_q  <= pop ? addr_word(head.addr) : cur_word;
                mem_wdata_q <= pop ? head.wdata : cur_wdata;
            end
            if (state == ACCESS)
                rd_cnt <= RD_CNT_INIT;
            else if ((state == RD_WAIT) && (rd_cnt != 2'd0))
                rd_cnt <= rd_cnt - 2'd1;
            if ((state == RD_WAIT) && (rd_cnt == 2'd0)) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= mem_rdata;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign req_ready  = !fifo_full;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign mem_cs_sel = (state == SELECT) ? cur_bank : sel_bank;
    assign mem_addr   = mem_addr_q;
    assign mem_rw     = (state == ACCESS) && (cur_we == RW_WRITE);
    assign mem_wdata  = mem_wdata_q;
    assign busy       = !fifo_empty || (state != IDLE);

endmodule
